// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a memory initiator (the core) and
// mem_responder.
//   Request  : req_valid, req_ready, req_we, req_addr (byte address), req_wdata
//   Response : resp_valid, resp_ready, resp_rdata, resp_err
// Modports: master = initiator side, slave = responder side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with a fixed access latency.
// Accepts one read/write request at a time, waits LATENCY cycles, performs the access
// on a 2**ADDR_WIDTH x 32-bit array and presents the response until it is consumed.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; aborts any transaction in flight and clears
//          the array
//   bus  - mem_responder_if.slave (request and response valid/ready channels)
// Parameters:
//   ADDR_WIDTH - log2 of word count; word index = req_addr[ADDR_WIDTH+1:2]
//   LATENCY    - wait cycles between acceptance and response (0..15)
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN
//   Defined     : misaligned requests (req_addr[1:0] != 0) leave the array untouched,
//                 return rdata 0 and resp_err = 1.
//   Not defined : req_addr[1:0] is ignored and resp_err is constant 0.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_responder_if.slave    bus
);

    localparam int unsigned Words  = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    mis_q, mis_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic                    mem_wr;
    logic [31:0]             mem_q [Words];

    // Address bits outside the word index only matter for the alignment check.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        mis_d        = mis_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_wr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = bus.req_addr[ADDR_WIDTH+1:2];
                    wdata_d = bus.req_wdata;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                    mis_d   = (bus.req_addr[1:0] != 2'b00);
`else
                    mis_d   = 1'b0;
`endif
                    cnt_d   = LatCnt;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = StResp;
                    resp_err_d = mis_q;
                    if (we_q) begin
                        mem_wr       = ~mis_q;
                        resp_rdata_d = 32'h0;
                    end else begin
                        resp_rdata_d = mis_q ? 32'h0 : mem_q[idx_q];
                    end
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs are registered copies of the next state.
        req_ready_d  = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'h0;
            mis_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            mis_q        <= mis_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Backing array; reset clears every word so an aborted write leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Words); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (mem_wr) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
    logic unused_err;
    assign unused_err = resp_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a word-array reference model.
module tb_mem_responder;

    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 2;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [2**AW];
    exp_t        sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the head of the
    // scoreboard; the entry retires on the handshake.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("resp_rdata", bus.resp_rdata, sb_q[0].rdata);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, sb_q[0].err});
                if (bus.resp_ready === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 2**AW; i++) model[i] = 32'h0;
        #1;
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete transaction; hold = cycles of resp_ready=0 backpressure in RESP.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold);
        exp_t        e;
        int          cnt;
        logic [7:0]  idx;
        bit          mis;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        idx   = addr[AW+1:2];
        mis   = AlignEn && (addr[1:0] != 2'b00);
        e.err = mis;
        if (we) begin
            e.rdata = 32'h0;
            if (!mis) model[idx] = wdata;
        end else begin
            e.rdata = mis ? 32'h0 : model[idx];
        end
        sb_q.push_back(e);
        #1;
        bus.req_valid = 1'b0;
        cnt = 0;
        while (bus.resp_valid !== 1'b1 && cnt < 40) begin
            chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", cnt, LAT + 1);
        if (cnt >= 40) begin
            apply_reset();
            return;
        end
        repeat (hold) begin
            chk("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
            chk("resp_valid_held", {31'd0, bus.resp_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        chk("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("resp_valid_drop", {31'd0, bus.resp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        apply_reset();

        // Directed scenarios.
        do_txn(1'b0, 32'h0000_0010, 32'h0, 0);
        do_txn(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h0000_0020, 32'h0, 0);
        do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 0);
        do_txn(1'b0, 32'h0000_0404, 32'h0, 0);
        do_txn(1'b0, 32'h0000_0004, 32'h0, 5);

        // Reset during WAIT of a write aborts it.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0008;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        apply_reset();
        do_txn(1'b0, 32'h0000_0008, 32'h0, 0);

        // Misaligned write then aligned read of the containing word.
        do_txn(1'b1, 32'h0000_0031, 32'hAAAA_AAAA, 0);
        do_txn(1'b0, 32'h0000_0030, 32'h0, 0);

        // Randomized traffic over a small word window with random upper address bits.
        for (int n = 0; n < 60; n++) begin
            a = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            do_txn(1'($urandom_range(0, 1)), a, $urandom(), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory interface.
- Accepts one read or write request at a time over a valid/ready handshake.
- Services the request after a fixed, parameterised access latency and returns a response over a valid/ready handshake.
- Replaces the zero-latency memory model so the core's control sequencing can be exercised against realistic, stalled memory.

Parameters:
- ADDR_WIDTH, 8, log2 of the number of 32-bit words in the backing array (256 words).
- LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- req_valid, input, 1, initiator presents a request.
- req_ready, output, 1, responder can accept a request this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, write data.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, initiator consumes the response.
- resp_rdata, output, 32, read data; 0 for write responses.
- resp_err, output, 1, error flag qualified by resp_valid; see Optional Feature.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0.
  - Every array word, all capture registers and resp_rdata cleared to 0.
  - req_ready=1, resp_valid=0, resp_err=0.
  - Asserting rst mid-transaction aborts it; a pending write is NOT committed.
- Word index = req_addr[ADDR_WIDTH+1:2]. Address bits above that are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, the request is accepted: capture req_we, the word index, req_wdata and alignment status; counter<=LATENCY; next state WAIT.
  - req_valid=0 -> remain in IDLE.
- WAIT:
  - req_ready=0; req_valid is ignored and must be held off by the initiator.
  - counter!=0 -> counter<=counter-1, stay in WAIT.
  - counter==0 -> perform the access and go to RESP:
    - Write: array[idx]<=wdata; resp_rdata<=0.
    - Read: resp_rdata<=array[idx].
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable while resp_ready=0 (unbounded backpressure).
  - On resp_ready=1 at a rising edge -> IDLE; resp_valid deasserts after that edge.
- Latency: a request accepted at edge N makes resp_valid visible after edge N+LATENCY+1. With LATENCY=0 the response appears after the next edge.
- Back-to-back: the earliest next acceptance is the edge after the response handshake, because req_ready rises only in IDLE. Maximum throughput is one transaction per LATENCY+3 cycles.
- Read-after-write to the same word returns the newly written data; the write is committed before the subsequent request is accepted.
- resp_rdata retains its value after leaving RESP; it is only meaningful while resp_valid=1.
- Simultaneous req_valid and resp_ready: they never overlap in effect, since each is sampled only in its own state.
- No combinational path from any input to any output; all outputs are decoded from registered state.

Optional Feature:
- Macro: MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0]!=0 is accepted and takes the normal latency.
  - The array is not modified and resp_rdata=0.
  - resp_err=1 while resp_valid=1.
  - Aligned requests return resp_err=0.
- Not defined:
  - req_addr[1:0] is ignored; misaligned addresses access the containing word.
  - resp_err is tied to constant 0.

Test Plan:
- Reset, then read addr 0x00000010 with LATENCY=2 -> req_ready=1 at acceptance; resp_valid appears exactly 3 edges after acceptance with resp_rdata=0x00000000.
- Write 0xDEADBEEF to 0x00000020, then read 0x00000020 -> write response resp_rdata=0; read response resp_rdata=0xDEADBEEF; req_ready=0 throughout both WAIT and RESP.
- Write 0x12345678 to 0x00000004, then read 0x00000404 (ADDR_WIDTH=8, wraps) -> resp_rdata=0x12345678.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata remain stable all 5 cycles; IDLE is reached only on the edge after resp_ready=1.
- Assert rst during WAIT of a write of 0xCAFEF00D to 0x00000008, then read 0x00000008 -> resp_rdata=0 (write aborted); after rst, resp_valid=0 and req_ready=1 immediately.
- With MEM_RESPONDER_ALIGN_CHECK_EN defined, write 0xAAAAAAAA to 0x00000031, then read 0x00000030 -> write response has resp_err=1; read returns 0 with resp_err=0. Without the macro, the same read returns 0xAAAAAAAA.
